serial_out_scheduler: RTL and testbench

- Shares one serial shift-out channel (data / shift clock / latch, 74HC595-style chain) between NUM_REQ requesters.
- Round-robin arbitrates 16-bit word requests and captures the granted word.
- Shifts the word out LSB-first on a divided shift clock, then issues an active-low latch pulse.
- Sits between producer blocks (display, LED, status registers) and the board-level serial pins.

---
 rtl/serial_out_scheduler_if.sv | 27 ++
 rtl/serial_out_scheduler.sv | 143 ++++++++++++++
 tb/tb_serial_out_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_out_scheduler_if.sv
// Bundle of requester-side and serial-pin signals for serial_out_scheduler.
// The slave modport is taken by the scheduler. The master modport is taken by
// whatever drives the requests and observes the serial pins.
interface serial_out_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       ack;
  logic [2:0]               cur_id;
  logic                     busy;
  logic                     done;
  logic                     s_out;
  logic                     s_clk;
  logic                     latch_n;

  modport master (
    output req, data_in,
    input  ack, cur_id, busy, done, s_out, s_clk, latch_n
  );

  modport slave (
    input  req, data_in,
    output ack, cur_id, busy, done, s_out, s_clk, latch_n
  );
endinterface

// File: rtl/serial_out_scheduler.sv
// Round-robin scheduler that shares one 74HC595-style serial chain.
// Several requesters use the chain in turn. A granted 16-bit word is shifted out LSB-first.
// Each bit lasts 2*CLK_DIV clk cycles: s_clk is low for the first half and high for the second.
// An active-low latch pulse of 2*CLK_DIV cycles follows the last bit.
//
//   state | meaning
//   IDLE  | arbitrate; on a grant pulse ack and capture the word
//   SHIFT | 16 bit periods, data changes only while s_clk is low
//   LATCH | latch_n low for 2*CLK_DIV cycles, s_out holds bit 15
module serial_out_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_out_scheduler_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               phase_q, phase_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [2:0]         cur_id_q, cur_id_d;
  logic               done_q, done_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic [NUM_REQ-1:0] ack_c;

  // Round-robin pick: scan from farthest to nearest so the closest set index at/after rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (bus.req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state, counters and grant pulse.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    cur_id_d  = cur_id_q;
    done_d    = 1'b0;
    ack_c     = '0;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        phase_d   = 1'b0;
        bit_cnt_d = '0;
        // A grant during the reset cycle would be thrown away, so it is not acknowledged.
        if (grant_found && !rst) begin
          ack_c[grant_idx] = 1'b1;
          shreg_d  = bus.data_in[int'(grant_idx)*WIDTH +: WIDTH];
          cur_id_d = 3'(grant_idx);
          rr_ptr_d = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          phase_d   = ~phase_q;
          if (phase_q) begin
            if (bit_cnt_q == BIT_LAST) state_d = LATCH;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        // Reuse the low/high half-period counter to time the 2*CLK_DIV latch window.
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (phase_q) begin
            phase_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            phase_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      cur_id_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      cur_id_q  <= cur_id_d;
      done_q    <= done_d;
    end
  end

  assign bus.ack     = ack_c;
  assign bus.cur_id  = cur_id_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.s_clk   = (state_q == SHIFT) && phase_q;
  assign bus.latch_n = (state_q != LATCH);
  assign bus.s_out   = (state_q != IDLE) ? shreg_q[bit_cnt_q] : 1'b0;

endmodule

// File: tb/tb_serial_out_scheduler.sv
// Bench for serial_out_scheduler. Two instances, CLK_DIV=2 and CLK_DIV=1, share one stimulus.
// Each instance is compared every cycle against a frame-offset reference model.
// A pin-level receiver rebuilds each shifted word and checks it at the latch edge.
module tb_serial_out_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;

  always #5 clk = ~clk;

  serial_out_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus0 ();
  serial_out_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) bus1 ();

  assign bus0.req = req;
  assign bus0.data_in = data_in;
  assign bus1.req = req;
  assign bus1.data_in = data_in;

  serial_out_scheduler #(.NUM_REQ(N), .WIDTH(W), .CLK_DIV(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  serial_out_scheduler #(.NUM_REQ(N), .WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
  endtask

  // Reference model state per instance: frame offset from the grant cycle (-1 = idle).
  int          m_off [2] = '{-1, -1};
  int          m_rr  [2] = '{0, 0};
  int          m_id  [2] = '{0, 0};
  logic [15:0] m_word[2] = '{16'h0, 16'h0};
  bit          m_done[2] = '{0, 0};

  // Pin-level receiver per instance.
  logic [15:0] rx     [2] = '{16'h0, 16'h0};
  int          rx_cnt [2] = '{0, 0};
  logic [15:0] rx_last[2] = '{16'h0, 16'h0};
  bit          p_sclk [2] = '{0, 0};
  bit          p_latch[2] = '{1, 1};

  int cycle = 0;
  int last_ack_cyc [2] = '{0, 0};
  int last_done_cyc[2] = '{0, 0};
  int g0_q[$];
  logic [N-1:0] pend_drop = '0;
  bit auto_drop = 1'b1;

  task automatic step(input int k, input logic [N-1:0] o_ack, input logic [2:0] o_id,
                      input logic o_busy, input logic o_done, input logic o_sout,
                      input logic o_sclk, input logic o_latch);
    int cd = (k == 0) ? 2 : 1;
    int g = -1;
    int idx;
    int o;
    int bitk;
    logic [N-1:0] e_ack = '0;
    logic [2:0] e_id = 3'd0;
    logic e_busy = 1'b0, e_done = 1'b0, e_sout = 1'b0, e_sclk = 1'b0, e_latch = 1'b1;
    if (rst) begin
      m_off[k] = -1; m_rr[k] = 0; m_done[k] = 0;
      rx_cnt[k] = 0; p_sclk[k] = 0; p_latch[k] = 1;
      return;
    end
    if (o_sclk && !p_sclk[k]) begin
      rx[k] = {o_sout, rx[k][15:1]};
      rx_cnt[k]++;
    end
    if (o_latch && !p_latch[k]) begin
      chk((k == 0) ? "rx_word0" : "rx_word1", rx[k], m_word[k]);
      chk((k == 0) ? "rx_bits0" : "rx_bits1", rx_cnt[k], 16);
      rx_last[k] = rx[k];
      rx_cnt[k] = 0;
    end
    p_sclk[k] = o_sclk;
    p_latch[k] = o_latch;

    e_done = m_done[k];
    m_done[k] = 0;
    if (m_off[k] < 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        idx = (m_rr[k] + i) % N;
        if (req[idx]) g = idx;
      end
      if (g >= 0) begin
        e_ack[g] = 1'b1;
        m_word[k] = data_in[g*W +: W];
        m_id[k] = g;
        m_rr[k] = (g + 1) % N;
        m_off[k] = 1;
      end
    end else begin
      o = m_off[k];
      e_busy = 1'b1;
      e_id = 3'(m_id[k]);
      if (o <= 32 * cd) begin
        bitk = (o - 1) / (2 * cd);
        e_sclk = ((o - 1) % (2 * cd)) >= cd;
        e_sout = m_word[k][bitk];
      end else begin
        e_latch = 1'b0;
        e_sout = m_word[k][15];
      end
      if (o == 34 * cd) begin
        m_off[k] = -1;
        m_done[k] = 1;
      end else begin
        m_off[k] = o + 1;
      end
    end
    chk((k == 0) ? "cyc0" : "cyc1",
        {o_ack, (e_busy ? o_id : 3'd0), o_busy, o_done, o_sout, o_sclk, o_latch},
        {e_ack, e_id, e_busy, e_done, e_sout, e_sclk, e_latch});
    if (o_ack != '0) begin
      last_ack_cyc[k] = cycle;
      if (k == 0)
        for (int i = 0; i < N; i++) if (o_ack[i]) g0_q.push_back(i);
    end
    if (o_done) last_done_cyc[k] = cycle;
  endtask

  // Outputs are sampled mid-cycle, half a period away from the active edge.
  always @(negedge clk) begin
    step(0, bus0.ack, bus0.cur_id, bus0.busy, bus0.done, bus0.s_out, bus0.s_clk, bus0.latch_n);
    step(1, bus1.ack, bus1.cur_id, bus1.busy, bus1.done, bus1.s_out, bus1.s_clk, bus1.latch_n);
    pend_drop = pend_drop | bus0.ack;
    cycle++;
  end

  // Requesters release req once the CLK_DIV=2 instance has acknowledged them.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~pend_drop;
    pend_drop = '0;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (g0_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk("grant_wait", g0_q.size(), n);
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    data_in[i*W +: W] = w;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", bus0.busy, 1'b0);
    chk("rst_latch", bus0.latch_n, 1'b1);

    // Single request, known word.
    set_word(0, 16'hA5C3);
    req = 4'b0001;
    wait_grants(1, 50);
    repeat (80) tick();
    chk("t1_grant", g0_q[0], 0);
    chk("t1_word", rx_last[0], 16'hA5C3);
    chk("t1_word_div1", rx_last[1], 16'hA5C3);
    chk("t1_lat_div2", last_done_cyc[0] - last_ack_cyc[0], 69);
    chk("t1_lat_div1", last_done_cyc[1] - last_ack_cyc[1], 35);

    // All four at once from a fresh pointer, then 0 and 3.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    g0_q.delete();
    for (int i = 0; i < N; i++) set_word(i, 16'($urandom));
    req = 4'b1111;
    wait_grants(4, 400);
    repeat (80) tick();
    for (int i = 0; i < 4; i++) chk("t2_order", g0_q[i], i);
    req = 4'b1001;
    wait_grants(6, 300);
    repeat (80) tick();
    chk("t2_pair_a", g0_q[4], 0);
    chk("t2_pair_b", g0_q[5], 3);

    // Fairness with two requesters held continuously.
    auto_drop = 1'b0;
    req = 4'b0101;
    wait_grants(10, 400);
    req = 4'b0000;
    auto_drop = 1'b1;
    repeat (80) tick();
    for (int i = 0; i < 4; i++) chk("t3_alt", g0_q[6+i], (i % 2 == 0) ? 0 : 2);

    // Word and request changes while the word is shifting.
    set_word(1, 16'h00FF);
    req = 4'b0010;
    wait_grants(11, 50);
    repeat (10) tick();
    req[1] = 1'b0;
    set_word(1, 16'h1234);
    tick();
    req[1] = 1'b1;
    wait_grants(12, 200);
    chk("t4_word", rx_last[0], 16'h00FF);
    chk("t4_regrant", g0_q[11], 1);
    chk("t4_after_done", last_ack_cyc[0], last_done_cyc[0]);
    repeat (80) tick();

    // Reset in the middle of bit 7.
    set_word(2, 16'($urandom));
    req = 4'b0100;
    wait_grants(13, 50);
    repeat (28) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", bus0.busy, 1'b0);
    chk("t5_sclk", bus0.s_clk, 1'b0);
    chk("t5_latch", bus0.latch_n, 1'b1);
    chk("t5_sout", bus0.s_out, 1'b0);
    chk("t5_done", bus0.done, 1'b0);
    req = 4'b1010;
    wait_grants(14, 50);
    chk("t5_restart", g0_q[13], 1);
    repeat (80) tick();

    // Randomized traffic, including early drops, data churn and one reset.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 99) < 4) begin
            req[i] = 1'b1;
            set_word(i, 16'($urandom));
          end else if ($urandom_range(0, 9) == 0) begin
            set_word(i, 16'($urandom));
          end
        end else if ($urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 49) == 0) begin
          set_word(i, 16'($urandom));
        end
      end
      rst = (c == 1500);
      tick();
    end
    rst = 1'b0;
    req = '0;
    repeat (100) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
